// File: rtl/shared_cnt_arb_pkg.sv
// Shared types and helpers for the shared-counter round-robin arbiter.
package shared_cnt_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_COOL  = 2'd2
    } state_e;

    localparam int unsigned COOL_W   = 4;
    localparam int unsigned MAX_NREQ = 8;
    localparam int unsigned IDX_W    = 3;

    // Encode a one-hot vector (at most MAX_NREQ wide) into its bit index.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_NREQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(MAX_NREQ); i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/shared_cnt_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer, cyclically.
// With SHARED_CNT_ARB_PRIO0_EN defined, requester 0 always wins when requesting.
module rr_pick
    import shared_cnt_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  pick_oh_o,
    output logic [IDX_W-1:0] pick_idx_o
);

    logic [MAX_NREQ-1:0] req_ext;
    logic [MAX_NREQ-1:0] oh_ext;
    logic [IDX_W-1:0]    cand;
    logic                found;

    assign req_ext = MAX_NREQ'(req_i);

    always_comb begin
        oh_ext = '0;
        cand   = '0;
        found  = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            cand = IDX_W'((int'(ptr_i) + i) % int'(NREQ));
            if (!found && req_ext[cand]) begin
                found        = 1'b1;
                oh_ext[cand] = 1'b1;
            end
        end
`ifdef SHARED_CNT_ARB_PRIO0_EN
        if (req_ext[0]) begin
            oh_ext = MAX_NREQ'(1);
        end
`endif
        pick_oh_o  = oh_ext[NREQ-1:0];
        pick_idx_o = onehot_to_idx(oh_ext);
    end

endmodule

// File: rtl/shared_cnt_arb.sv
// Round-robin arbiter sequencing NREQ increment sources into one shared modulo counter.
// Optional: define SHARED_CNT_ARB_PRIO0_EN to give requester 0 absolute priority.
module shared_cnt_arb
    import shared_cnt_arb_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned CNT_W   = 3,
    parameter int unsigned CNT_MAX = 5,
    parameter int unsigned COOL    = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [NREQ-1:0]  REQ,
    input  logic             CLEAR,
    output logic [NREQ-1:0]  GNT,
    output logic             GNT_VALID,
    output logic [CNT_W-1:0] CNT,
    output logic             CNT_WRAP,
    output logic             BUSY
);

    localparam int unsigned COOL_LOAD = (COOL == 0) ? 0 : COOL - 1;

    state_e            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              gnt_valid_q, gnt_valid_d;
    logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [COOL_W-1:0] cool_q, cool_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wrap_q, wrap_d;
    logic              busy_q, busy_d;

    logic [NREQ-1:0]   pick_oh;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  ptr_inc;

    rr_pick #(
        .NREQ(NREQ)
    ) u_rr_pick (
        .req_i      (REQ),
        .ptr_i      (ptr_q),
        .pick_oh_o  (pick_oh),
        .pick_idx_o (pick_idx)
    );

    assign ptr_inc = (gnt_idx_q == IDX_W'(NREQ - 1)) ? '0 : IDX_W'(gnt_idx_q + 1'b1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_idx_q   <= '0;
            ptr_q       <= '0;
            cool_q      <= '0;
            cnt_q       <= '0;
            wrap_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_idx_q   <= gnt_idx_d;
            ptr_q       <= ptr_d;
            cool_q      <= cool_d;
            cnt_q       <= cnt_d;
            wrap_q      <= wrap_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state, pointer, cooldown and shared-counter update.
    always_comb begin
        state_d     = state_q;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        gnt_idx_d   = gnt_idx_q;
        ptr_d       = ptr_q;
        cool_d      = cool_q;
        cnt_d       = CLEAR ? '0 : cnt_q;
        wrap_d      = 1'b0;
        busy_d      = busy_q;

        unique case (state_q)
            ST_IDLE: begin
                if (REQ != '0) begin
                    state_d     = ST_GRANT;
                    gnt_d       = pick_oh;
                    gnt_valid_d = 1'b1;
                    gnt_idx_d   = pick_idx;
                    busy_d      = 1'b1;
                end
            end
            ST_GRANT: begin
                if (CLEAR) begin
                    cnt_d = '0;
                end else if (cnt_q >= CNT_W'(CNT_MAX)) begin
                    cnt_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
`ifdef SHARED_CNT_ARB_PRIO0_EN
                if (gnt_idx_q != '0) ptr_d = ptr_inc;
`else
                ptr_d = ptr_inc;
`endif
                if (COOL == 0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    state_d = ST_COOL;
                    cool_d  = COOL_W'(COOL_LOAD);
                end
            end
            ST_COOL: begin
                if (cool_q == '0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cool_d = COOL_W'(cool_q - 1'b1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign GNT       = gnt_q;
    assign GNT_VALID = gnt_valid_q;
    assign CNT       = cnt_q;
    assign CNT_WRAP  = wrap_q;
    assign BUSY      = busy_q;

endmodule
